// File: rtl/axi_stream_packet_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_INPUTS AXI4-Stream slaves onto one
// registered master port; a grant is held until the TLAST beat is accepted.
module axi_stream_packet_arbiter #(
    parameter  int NUM_INPUTS = 4,
    parameter  int byte_width = 4,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [NUM_INPUTS-1:0]              s_tvalid,
    output logic [NUM_INPUTS-1:0]              s_tready,
    input  logic [NUM_INPUTS*8*byte_width-1:0] s_tdata,
    input  logic [NUM_INPUTS*byte_width-1:0]   s_tkeep,
    input  logic [NUM_INPUTS-1:0]              s_tlast,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [8*byte_width-1:0]            m_tdata,
    output logic [byte_width-1:0]              m_tkeep,
    output logic                               m_tlast,
    output logic [IDX_W-1:0]                   m_tid,
    output logic                               busy,
    output logic [IDX_W-1:0]                   grant_idx
);

    localparam int DW = 8 * byte_width;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      last_grant;
    logic [DW-1:0]         data_arr [NUM_INPUTS];
    logic [byte_width-1:0] keep_arr [NUM_INPUTS];
    logic                  out_ready;
    logic                  accept;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick;
    logic [IDX_W-1:0]      cand;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_split
        assign data_arr[i] = s_tdata[i*DW +: DW];
        assign keep_arr[i] = s_tkeep[i*byte_width +: byte_width];
    end

    // The output register can take a new beat when empty or being drained this cycle.
    assign out_ready = !m_tvalid || m_tready;
    assign accept    = (state == LOCKED) && s_tvalid[grant_idx] && out_ready;
    assign busy      = (state == LOCKED);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        s_tready = '0;
        if (state == LOCKED) begin
            s_tready[grant_idx] = out_ready;
        end
    end

    // Round-robin search starting one past the most recently finished packet.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_INPUTS);
            if (!pick_valid && s_tvalid[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_INPUTS - 1);
            grant_idx  <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b0;
            m_tid      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick;
                        state     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && s_tlast[grant_idx]) begin
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= data_arr[grant_idx];
                m_tkeep  <= keep_arr[grant_idx];
                m_tlast  <= s_tlast[grant_idx];
                m_tid    <= grant_idx;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed bench for axi_stream_packet_arbiter: queued per-input packet sources,
// an output beat recorder and hand-computed expected beat sequences.
module tb_axi_stream_packet_arbiter;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        bit            last;
    } beat_t;

    typedef struct {
        int            tid;
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        bit            last;
        int            cyc;
    } obs_t;

    logic              clk;
    logic              resetn;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*BW-1:0]   s_tkeep;
    logic [N-1:0]      s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [BW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              busy;
    logic [IW-1:0]     grant_idx;

    logic [DW-1:0]     tb_data [N];
    logic [BW-1:0]     tb_keep [N];
    beat_t             src_q [N][$];
    obs_t              out_q [$];
    bit                stall [N];
    int                cyc;
    int                busy_cnt;
    int                checks;
    int                errors;

    assign s_tdata = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
    assign s_tkeep = {tb_keep[3], tb_keep[2], tb_keep[1], tb_keep[0]};

    axi_stream_packet_arbiter #(
        .NUM_INPUTS(N),
        .byte_width(BW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .busy     (busy),
        .grant_idx(grant_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t beat_at(input int k);
        obs_t o;
        o = '{-1, '0, '0, 1'b0, -1};
        if (k < out_q.size()) o = out_q[k];
        return o;
    endfunction

    task automatic check_beat(input string tag, input int k, input int tid,
                              input logic [DW-1:0] data, input logic [BW-1:0] keep, input bit last);
        obs_t o;
        o = beat_at(k);
        check({tag, "_tid"}, o.tid, tid);
        check({tag, "_data"}, o.data, data);
        check({tag, "_keep"}, o.keep, keep);
        check({tag, "_last"}, o.last, last);
    endtask

    task automatic push(input int i, input logic [DW-1:0] data, input logic [BW-1:0] keep, input bit last);
        beat_t b;
        b.data = data;
        b.keep = keep;
        b.last = last;
        src_q[i].push_back(b);
    endtask

    task automatic wait_out(input int n, input string tag);
        int budget;
        budget = 300;
        while (out_q.size() < n && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check({tag, "_beat_count"}, out_q.size(), n);
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            stall[i] = 1'b0;
        end
    endtask

    task automatic do_reset(input logic ready);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        clear_sources();
        m_tready = ready;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        out_q.delete();
    endtask

    // Source driver and output recorder: handshakes are sampled mid-cycle, sources
    // advance just after the edge that completed their handshake.
    initial begin
        logic [N-1:0] hs;
        s_tvalid = '0;
        s_tlast  = '0;
        cyc      = 0;
        for (int i = 0; i < N; i++) begin
            tb_data[i] = '0;
            tb_keep[i] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            hs = s_tvalid & s_tready;
            if (m_tvalid && m_tready) out_q.push_back('{int'(m_tid), m_tdata, m_tkeep, m_tlast, cyc});
            if (busy) busy_cnt++;
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && !stall[i]) begin
                    s_tvalid[i] = 1'b1;
                    s_tlast[i]  = src_q[i][0].last;
                    tb_data[i]  = src_q[i][0].data;
                    tb_keep[i]  = src_q[i][0].keep;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                    tb_data[i]  = '0;
                    tb_keep[i]  = '0;
                end
            end
        end
    end

    initial begin
        int budget;
        int k;
        checks   = 0;
        errors   = 0;
        busy_cnt = 0;
        resetn   = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) stall[i] = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tid", m_tid, 0);
        resetn = 1'b1;

        // Single source on input 2
        busy_cnt = 0;
        push(2, 32'hA1, 4'hF, 1'b0);
        push(2, 32'hA2, 4'hF, 1'b0);
        push(2, 32'hA3, 4'h3, 1'b1);
        wait_out(3, "t1");
        repeat (3) @(negedge clk);
        #1;
        check_beat("t1_b0", 0, 2, 32'hA1, 4'hF, 1'b0);
        check_beat("t1_b1", 1, 2, 32'hA2, 4'hF, 1'b0);
        check_beat("t1_b2", 2, 2, 32'hA3, 4'h3, 1'b1);
        check("t1_gap01", beat_at(1).cyc - beat_at(0).cyc, 1);
        check("t1_gap12", beat_at(2).cyc - beat_at(1).cyc, 1);
        check("t1_busy_cycles", busy_cnt, 3);

        // Round robin: every input offers two 2-beat packets
        do_reset(1'b1);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                for (int b = 0; b < 2; b++)
                    push(i, 32'h2000_0000 | 32'(i << 8) | 32'(p << 4) | 32'(b), 4'hF, b == 1);
        wait_out(16, "t2");
        k = 0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                for (int b = 0; b < 2; b++) begin
                    check_beat($sformatf("t2_k%0d", k), k, i,
                               32'h2000_0000 | 32'(i << 8) | 32'(p << 4) | 32'(b), 4'hF, b == 1);
                    k++;
                end
        for (int j = 1; j < 16; j++)
            check($sformatf("t2_gap%0d", j), beat_at(j).cyc - beat_at(j - 1).cyc, (j % 2 == 0) ? 2 : 1);

        // Backpressure on input 1
        do_reset(1'b0);
        push(1, 32'h11223344, 4'hF, 1'b0);
        push(1, 32'h55667788, 4'hF, 1'b0);
        push(1, 32'h99AABBCC, 4'hF, 1'b1);
        budget = 50;
        while (!m_tvalid && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check("t3_m_tvalid_seen", m_tvalid, 1);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("t3_hold_data%0d", j), m_tdata, 32'h11223344);
            check($sformatf("t3_hold_valid%0d", j), m_tvalid, 1);
            check($sformatf("t3_hold_tid%0d", j), m_tid, 1);
            check($sformatf("t3_hold_sready%0d", j), s_tready[1], 0);
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_out(3, "t3");
        repeat (5) @(negedge clk);
        #1;
        check("t3_total_beats", out_q.size(), 3);
        check_beat("t3_b0", 0, 1, 32'h11223344, 4'hF, 1'b0);
        check_beat("t3_b1", 1, 1, 32'h55667788, 4'hF, 1'b0);
        check_beat("t3_b2", 2, 1, 32'h99AABBCC, 4'hF, 1'b1);

        // No interleave: input 0 stalls mid-packet while input 1 waits
        do_reset(1'b1);
        for (int b = 0; b < 4; b++) push(0, 32'h4000 + 32'(b), 4'hF, b == 3);
        for (int b = 0; b < 2; b++) push(1, 32'h4100 + 32'(b), 4'hF, b == 1);
        wait_out(1, "t4_first");
        @(posedge clk);
        #1;
        stall[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            check($sformatf("t4_stall_grant%0d", j), grant_idx, 0);
            check($sformatf("t4_stall_busy%0d", j), busy, 1);
            check($sformatf("t4_stall_sready1_%0d", j), s_tready[1], 0);
        end
        @(posedge clk);
        #1;
        stall[0] = 1'b0;
        wait_out(6, "t4");
        for (int b = 0; b < 4; b++)
            check_beat($sformatf("t4_in0_b%0d", b), b, 0, 32'h4000 + 32'(b), 4'hF, b == 3);
        for (int b = 0; b < 2; b++)
            check_beat($sformatf("t4_in1_b%0d", b), 4 + b, 1, 32'h4100 + 32'(b), 4'hF, b == 1);
        check("t4_stall_gap", beat_at(2).cyc - beat_at(1).cyc, 4);

        // Skip idle requesters with wrap-around after last_grant=1
        do_reset(1'b1);
        push(1, 32'h51, 4'hF, 1'b1);
        wait_out(1, "t5_first");
        repeat (3) @(negedge clk);
        #1;
        push(0, 32'h50, 4'hF, 1'b1);
        budget = 50;
        while (!busy && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check("t5_busy", busy, 1);
        check("t5_grant_idx", grant_idx, 0);
        wait_out(2, "t5");
        check_beat("t5_b0", 0, 1, 32'h51, 4'hF, 1'b1);
        check_beat("t5_b1", 1, 0, 32'h50, 4'hF, 1'b1);

        // Async reset mid-packet, then a lone request from input 3
        out_q.delete();
        for (int b = 0; b < 4; b++) push(2, 32'h6000 + 32'(b), 4'hF, b == 3);
        wait_out(1, "t6_first");
        #2;
        resetn = 1'b0;
        clear_sources();
        #1;
        check("t6_m_tvalid", m_tvalid, 0);
        check("t6_s_tready", s_tready, 0);
        check("t6_busy", busy, 0);
        check("t6_grant_idx", grant_idx, 0);
        check("t6_m_tdata", m_tdata, 0);
        check("t6_m_tkeep", m_tkeep, 0);
        check("t6_m_tlast", m_tlast, 0);
        check("t6_m_tid", m_tid, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        out_q.delete();
        push(3, 32'hD3, 4'hF, 1'b1);
        wait_out(1, "t6");
        check_beat("t6_b0", 0, 3, 32'hD3, 4'hF, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check("t6_total_beats", out_q.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_stream_packet_arbiter.md
# axi_stream_packet_arbiter

Packet-aware round-robin arbiter that merges NUM_INPUTS AXI4-Stream slave ports onto one AXI4-Stream master port. A grant is held from the first beat of a packet until its TLAST beat is accepted, so packets are never interleaved. The master side is fully registered, and the source index is emitted on TID. It sits in front of shared stream consumers (DMA write channel, packet FIFO, egress MAC) and is checked with the team's AXI-Stream master/slave property sets.

## Interface
- NUM_INPUTS, 4: number of slave ports, legal range 2..16.
- byte_width, 4: TDATA width in bytes, ≥1; TKEEP is byte_width bits.
- IDX_W (localparam), $clog2(NUM_INPUTS): index and TID width.

- clk  in  1  clock; all logic on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- s_tvalid  in  NUM_INPUTS  per-input TVALID.
- s_tready  out  NUM_INPUTS  per-input TREADY; at most one bit high.
- s_tdata  in  NUM_INPUTS*8*byte_width  input i occupies slice i.
- s_tkeep  in  NUM_INPUTS*byte_width  input i occupies slice i.
- s_tlast  in  NUM_INPUTS  per-input TLAST.
- m_tvalid  out  1  registered.
- m_tready  in  1  downstream ready.
- m_tdata  out  8*byte_width  registered.
- m_tkeep  out  byte_width  registered.
- m_tlast  out  1  registered.
- m_tid  out  IDX_W  registered; index of the input that supplied the beat.
- busy  out  1  high while in LOCKED state.
- grant_idx  out  IDX_W  current or most recent grant.

## Operation
- States: IDLE, LOCKED. last_grant register resets to NUM_INPUTS-1, so the first grant goes to input 0.
- IDLE:
  - s_tready is all zeros.
  - If any s_tvalid is high, select the first requester searching upward from last_grant+1 (mod NUM_INPUTS).
  - Register it into grant_idx and move to LOCKED.
  - If no s_tvalid is high, stay in IDLE.
- LOCKED:
  - s_tready[grant_idx] = !m_tvalid || m_tready. All other bits are 0.
  - A beat is accepted when s_tvalid[g] && s_tready[g]. On acceptance, the beat's tdata, tkeep and tlast are loaded into the output register, m_tid <= g, and m_tvalid <= 1.
  - When the accepted beat has tlast=1: last_grant <= g and the state returns to IDLE.
- Output register:
  - If m_tvalid && m_tready and no new beat is loaded, m_tvalid <= 0.
  - While m_tvalid && !m_tready, m_tdata, m_tkeep, m_tlast and m_tid are held stable and m_tvalid stays high.
- The input data path for the granted port is a mux indexed by grant_idx. There are no combinational paths from s_* to m_*.
- The granted input dropping s_tvalid mid-packet is legal. The arbiter stays LOCKED on that input; there is no timeout and no preemption.
- Inputs with s_tvalid low are skipped. A requester is never starved: at most NUM_INPUTS-1 packets are served before it.

## Timing
- Reset values (async assert, synchronous release):
  - state=IDLE, last_grant=NUM_INPUTS-1, grant_idx=0.
  - s_tready=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, m_tid=0, busy=0.
- Arbitration costs one bubble cycle per packet: request seen in IDLE at cycle N, grant registered at edge N+1, first s_tready high during cycle N+1.
- Latency: a beat accepted at edge k appears on m_* starting at edge k (visible in cycle k+1).
- With m_tready held high and the source streaming, throughput is 1 beat/cycle within a packet. A P-beat packet occupies P+1 cycles.
- The tlast acceptance edge and the next arbitration do not overlap. The cycle after tlast is accepted is spent in IDLE.
- Reset mid-packet:
  - m_tvalid drops immediately.
  - The partial packet is discarded.
  - Arbitration restarts at input 0.

## Test plan
- Single source: input 2 sends a 3-beat packet (0xA1, 0xA2, 0xA3, last on the third beat) with m_tready=1 -> m_* shows the three beats in consecutive cycles with m_tid=2 and m_tlast on beat 3; busy is high for 3 cycles.
- Round robin: all 4 inputs continuously offer 2-beat packets -> the grant order is 0,1,2,3,0,1, and there is exactly one idle cycle between packets.
- Backpressure: m_tready=0 for 5 cycles while m_tvalid=1 with m_tdata=0x11223344 -> m_* is stable, s_tready[g]=0, and no beat is lost or duplicated after release.
- No interleave: inputs 0 and 1 both valid; input 0 stalls s_tvalid for 3 cycles mid-packet -> no beat from input 1 appears until input 0's tlast has been output.
- Skip idle requesters: last_grant=1, only input 0 valid -> grant_idx=0 (wrap-around from index 3 to 0).
- Async reset asserted mid-packet -> all outputs go to their reset values without a clock edge. After release, a request from input 3 alone -> granted, with m_tid=3.
